// File: rtl/gf2_pdiv64.sv
// gf2_pdiv64 -- sequential GF(2) polynomial long divider.
//
// Divides a (2N-1)-bit dividend n by an N-bit divisor m over GF(2) and
// returns quotient q and remainder r such that n = q*m ^ r, deg r < deg m.
// The divisor is first left-normalised so its leading coefficient sits at
// bit N-1. After that, one quotient bit is retired per cycle, from x^(2N-2)
// down to x^(deg m).
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset; aborts any operation
//   in_valid   n/m valid
//   in_ready   operand pair can be accepted (IDLE and not in reset)
//   n [2N-2:0] dividend, bit i = coefficient of x^i
//   m [N-1:0]  divisor, bit i = coefficient of x^i
//   out_valid  q/r/err valid, held until out_ready
//   out_ready  downstream accepts the result
//   q [2N-2:0] quotient
//   r [N-2:0]  remainder (bits at index >= deg m are zero)
//   err        divisor was zero
module gf2_pdiv64 #(
    parameter int N = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-2:0] n,
    input  logic [N-1:0]   m,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-2:0] q,
    output logic [N-2:0]   r,
    output logic           err
);

    localparam int WW = 2 * N - 1;       // dividend / quotient width
    localparam int SW = $clog2(N);       // normalisation shift count width
    localparam int KW = $clog2(2 * N);   // division step counter width

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] NORM = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]    state;
    logic [WW-1:0] w;      // working remainder
    logic [WW-1:0] d;      // aligned divisor, leading 1 tracks bit idx
    logic [WW-1:0] qs;     // quotient shift register
    logic [N-1:0]  mr;     // divisor being normalised
    logic [SW-1:0] s;      // normalisation shift = N-1 - deg m
    logic [KW-1:0] k;      // division step
    logic [KW-1:0] idx;    // coefficient examined this step
    logic          lead;
    logic          last;
    logic          m_zero;

    assign idx    = KW'(WW - 1) - k;
    assign lead   = w[idx];
    // The final step examines coefficient x^(deg m), i.e. k = N-1 + s.
    assign last   = (k == KW'(N - 1) + KW'(s));
    assign m_zero = (m == '0);

    assign in_ready = (state == IDLE) && !rst;
    assign q        = qs;
    assign r        = w[N-2:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            w         <= '0;
            d         <= '0;
            qs        <= '0;
            mr        <= '0;
            s         <= '0;
            k         <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // A zero divisor skips straight to DONE with a zero
                        // remainder, so the dividend is not loaded.
                        w         <= m_zero ? '0 : n;
                        mr        <= m;
                        s         <= '0;
                        k         <= '0;
                        qs        <= '0;
                        err       <= m_zero;
                        out_valid <= m_zero;
                        state     <= m_zero ? DONE : NORM;
                    end
                end
                NORM: begin
                    if (mr[N-1]) begin
                        d     <= {mr, {(N - 1){1'b0}}};
                        k     <= '0;
                        state <= DIV;
                    end else begin
                        mr <= mr << 1;
                        s  <= s + 1'b1;
                    end
                end
                DIV: begin
                    qs <= {qs[WW-2:0], lead};
                    if (lead) begin
                        w <= w ^ d;
                    end
                    d <= d >> 1;
                    k <= k + 1'b1;
                    if (last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
